// File: rtl/stagewb.sv
// MEM/WB pipeline register plus writeback datapath (load extraction, rd write port).
// Optional retired-instruction counter enabled by defining STAGEWB_INSTRET_EN.
module stagewb (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        valid_mem,
    input  logic [31:0] pc_mem,
    input  logic [4:0]  rd_addr_mem,
    input  logic        rd_wren_mem,
    input  logic [1:0]  wb_sel_mem,
    input  logic [3:0]  lsu_op_mem,
    input  logic [31:0] alu_data_mem,
    input  logic [31:0] ld_data,
    output logic        valid_wb,
    output logic [31:0] pc_wb,
    output logic [4:0]  rd_addr_wb,
    output logic        rd_wren_wb,
    output logic [31:0] rd_data_wb
`ifdef STAGEWB_INSTRET_EN
    ,
    output logic [63:0] instret_wb
`endif
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [4:0]  rd_addr_q;
    logic        rd_wren_q;
    logic [1:0]  wb_sel_q;
    logic [2:0]  lsu_op_q;
    logic [31:0] alu_data_q;
    logic [31:0] ld_data_q;

    // lsu_op bit 3 carries nothing the writeback stage needs
    logic unused_lsu_op_bit3;
    assign unused_lsu_op_bit3 = lsu_op_mem[3];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rd_addr_q  <= '0;
            rd_wren_q  <= 1'b0;
            wb_sel_q   <= '0;
            lsu_op_q   <= '0;
            alu_data_q <= '0;
            ld_data_q  <= '0;
        end else if (!i_stall) begin
            valid_q    <= valid_mem;
            pc_q       <= pc_mem;
            rd_addr_q  <= rd_addr_mem;
            rd_wren_q  <= rd_wren_mem & valid_mem;
            wb_sel_q   <= wb_sel_mem;
            lsu_op_q   <= lsu_op_mem[2:0];
            alu_data_q <= alu_data_mem;
            ld_data_q  <= ld_data;
        end
    end

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    always_comb begin
        lane_byte = ld_data_q[7:0];
        case (alu_data_q[1:0])
            2'd0: lane_byte = ld_data_q[7:0];
            2'd1: lane_byte = ld_data_q[15:8];
            2'd2: lane_byte = ld_data_q[23:16];
            2'd3: lane_byte = ld_data_q[31:24];
            default: lane_byte = ld_data_q[7:0];
        endcase
        lane_half = alu_data_q[1] ? ld_data_q[31:16] : ld_data_q[15:0];

        load_data = ld_data_q;
        case (lsu_op_q[1:0])
            2'b00: load_data = lsu_op_q[2] ? {24'b0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            2'b01: load_data = lsu_op_q[2] ? {16'b0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default: load_data = ld_data_q;
        endcase
    end

    always_comb begin
        rd_data_wb = '0;
        case (wb_sel_q)
            2'b00: rd_data_wb = alu_data_q;
            2'b01: rd_data_wb = load_data;
            2'b10: rd_data_wb = pc_q + 32'd4;
            default: rd_data_wb = '0;
        endcase
    end

    assign valid_wb   = valid_q;
    assign pc_wb      = pc_q;
    assign rd_addr_wb = rd_addr_q;
    assign rd_wren_wb = rd_wren_q & (rd_addr_q != 5'd0);

`ifdef STAGEWB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instret_q <= '0;
        end else if (valid_mem && !i_stall && !i_flush) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_wb = instret_q;
`endif

endmodule

// File: tb/tb_stagewb.sv
// Directed self-checking bench for stagewb; counter checks are built only when
// STAGEWB_INSTRET_EN is defined.
module tb_stagewb;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_stall;
    logic        i_flush;
    logic        valid_mem;
    logic [31:0] pc_mem;
    logic [4:0]  rd_addr_mem;
    logic        rd_wren_mem;
    logic [1:0]  wb_sel_mem;
    logic [3:0]  lsu_op_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] ld_data;
    logic        valid_wb;
    logic [31:0] pc_wb;
    logic [4:0]  rd_addr_wb;
    logic        rd_wren_wb;
    logic [31:0] rd_data_wb;
`ifdef STAGEWB_INSTRET_EN
    logic [63:0] instret_wb;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 i_clk = ~i_clk;

    stagewb dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .valid_mem    (valid_mem),
        .pc_mem       (pc_mem),
        .rd_addr_mem  (rd_addr_mem),
        .rd_wren_mem  (rd_wren_mem),
        .wb_sel_mem   (wb_sel_mem),
        .lsu_op_mem   (lsu_op_mem),
        .alu_data_mem (alu_data_mem),
        .ld_data      (ld_data),
        .valid_wb     (valid_wb),
        .pc_wb        (pc_wb),
        .rd_addr_wb   (rd_addr_wb),
        .rd_wren_wb   (rd_wren_wb),
`ifdef STAGEWB_INSTRET_EN
        .instret_wb   (instret_wb),
`endif
        .rd_data_wb   (rd_data_wb)
    );

    // Drive MEM-stage inputs (stimulus only), then advance one edge and settle.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wren, input logic [1:0] sel, input logic [3:0] op,
                         input logic [31:0] alu, input logic [31:0] ld);
        valid_mem    = v;
        pc_mem       = pc;
        rd_addr_mem  = rd;
        rd_wren_mem  = wren;
        wb_sel_mem   = sel;
        lsu_op_mem   = op;
        alu_data_mem = alu;
        ld_data      = ld;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        drive(1'b1, 32'hDEAD_BEEC, 5'd9, 1'b1, 2'b10, 4'b0010, 32'h1234_5678, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_0100, 5'd3, 1'b1, 2'b00, 4'b0000, 32'hCAFE_F00D, 32'h0F0F_0F0F);
        tests_run++;
        if (valid_wb !== 1'b0 || pc_wb !== 32'd0 || rd_addr_wb !== 5'd0 ||
            rd_wren_wb !== 1'b0 || rd_data_wb !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b pc=%h rd=%0d wren=%b data=%h, required all 0",
                     valid_wb, pc_wb, rd_addr_wb, rd_wren_wb, rd_data_wb);
        end
        i_reset = 1'b0;
        drive(1'b1, 32'h0000_0200, 5'd4, 1'b1, 2'b00, 4'b0000, 32'h0000_0042, 32'd0);
        tests_run++;
        if (valid_wb !== 1'b1 || pc_wb !== 32'h200 || rd_data_wb !== 32'h42 || rd_wren_wb !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: valid=%b pc=%h data=%h wren=%b, required 1 00000200 00000042 1",
                     valid_wb, pc_wb, rd_data_wb, rd_wren_wb);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  ops [8] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                                 4'b0000, 4'b0001, 4'b0111};
        logic [31:0] addrs [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1002, 32'h1000,
                                   32'h1003, 32'h1001, 32'h1003};
        logic [31:0] exps [8] = '{32'hFFFF_FF85, 32'h0000_007F, 32'hFFFF_80F1, 32'h0000_80F1,
                                  32'h80F1_7F85, 32'hFFFF_FF80, 32'h0000_7F85, 32'h80F1_7F85};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h400, 5'd3, 1'b1, 2'b01, ops[i], addrs[i], 32'h80F1_7F85);
            tests_run++;
            if (rd_data_wb !== exps[i]) begin
                tests_failed++;
                $display("FAIL load_%0d op=%b addr=%h: got %h, required %h",
                         i, ops[i], addrs[i], rd_data_wb, exps[i]);
            end
        end
    endtask

    task automatic test_jal();
        drive(1'b1, 32'h0000_0FFC, 5'd1, 1'b1, 2'b10, 4'b0000, 32'h5555_5555, 32'd0);
        tests_run++;
        if (rd_data_wb !== 32'h0000_1000) begin
            tests_failed++;
            $display("FAIL jal_link: got %h, required 00001000", rd_data_wb);
        end
        drive(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 4'b0000, 32'h5555_5555, 32'd0);
        tests_run++;
        if (rd_data_wb !== 32'h0000_0000 || pc_wb !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL jal_wrap: data=%h pc=%h, required 00000000 fffffffc", rd_data_wb, pc_wb);
        end
        drive(1'b1, 32'h0000_0FFC, 5'd1, 1'b1, 2'b11, 4'b0000, 32'h5555_5555, 32'hFFFF_FFFF);
        tests_run++;
        if (rd_data_wb !== 32'd0) begin
            tests_failed++;
            $display("FAIL wbsel_reserved: got %h, required 00000000", rd_data_wb);
        end
    endtask

    task automatic test_x0_guard();
        drive(1'b1, 32'h10, 5'd0, 1'b1, 2'b00, 4'b0000, 32'h0000_1234, 32'd0);
        tests_run++;
        if (rd_wren_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_guard: wren=%b, required 0", rd_wren_wb);
        end
        drive(1'b1, 32'h14, 5'd5, 1'b1, 2'b00, 4'b0000, 32'h0000_1234, 32'd0);
        tests_run++;
        if (rd_wren_wb !== 1'b1 || rd_data_wb !== 32'h1234 || rd_addr_wb !== 5'd5) begin
            tests_failed++;
            $display("FAIL x5_write: wren=%b data=%h rd=%0d, required 1 00001234 5",
                     rd_wren_wb, rd_data_wb, rd_addr_wb);
        end
        drive(1'b0, 32'h18, 5'd6, 1'b1, 2'b00, 4'b0000, 32'h0000_9999, 32'd0);
        tests_run++;
        if (rd_wren_wb !== 1'b0 || valid_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_no_write: wren=%b valid=%b, required 0 0", rd_wren_wb, valid_wb);
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h800, 5'd7, 1'b1, 2'b00, 4'b0000, 32'hA5A5_A5A5, 32'd0);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h900 + i, 5'd8 + 5'(i), 1'b0, 2'b10, 4'b0001, 32'h1111_0000 + i, 32'hFFFF_FFFF);
            tests_run++;
            if (rd_data_wb !== 32'hA5A5_A5A5 || valid_wb !== 1'b1 || rd_wren_wb !== 1'b1 ||
                rd_addr_wb !== 5'd7 || pc_wb !== 32'h800) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: data=%h valid=%b wren=%b rd=%0d pc=%h, required a5a5a5a5 1 1 7 00000800",
                         i, rd_data_wb, valid_wb, rd_wren_wb, rd_addr_wb, pc_wb);
            end
        end
        i_flush = 1'b1;
        drive(1'b1, 32'hA00, 5'd9, 1'b1, 2'b00, 4'b0000, 32'h7777_7777, 32'd0);
        tests_run++;
        if (valid_wb !== 1'b0 || rd_wren_wb !== 1'b0 || rd_data_wb !== 32'd0) begin
            tests_failed++;
            $display("FAIL stall_flush_bubble: valid=%b wren=%b data=%h, required 0 0 00000000",
                     valid_wb, rd_wren_wb, rd_data_wb);
        end
        i_stall = 1'b0; i_flush = 1'b0;
        drive(1'b1, 32'hB00, 5'd10, 1'b1, 2'b00, 4'b0000, 32'h0BAD_CAFE, 32'd0);
        i_stall = 1'b1; i_reset = 1'b1;
        drive(1'b1, 32'hC00, 5'd11, 1'b1, 2'b00, 4'b0000, 32'h3333_3333, 32'd0);
        tests_run++;
        if (valid_wb !== 1'b0 || rd_data_wb !== 32'd0 || pc_wb !== 32'd0 || rd_addr_wb !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: valid=%b data=%h pc=%h rd=%0d, required all 0",
                     valid_wb, rd_data_wb, pc_wb, rd_addr_wb);
        end
        i_stall = 1'b0; i_reset = 1'b0;
    endtask

`ifdef STAGEWB_INSTRET_EN
    task automatic test_instret();
        logic st [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        logic fl [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        i_reset = 1'b1;
        drive(1'b1, 32'd0, 5'd1, 1'b1, 2'b00, 4'b0000, 32'd0, 32'd0);
        i_reset = 1'b0;
        tests_run++;
        if (instret_wb !== 64'd0) begin
            tests_failed++;
            $display("FAIL instret_reset: got %0d, required 0", instret_wb);
        end
        for (int i = 0; i < 10; i++) begin
            i_stall = st[i];
            i_flush = fl[i];
            drive(1'b1, 32'h100 + 32'(4 * i), 5'd2, 1'b1, 2'b00, 4'b0000, 32'(i), 32'd0);
        end
        i_stall = 1'b0; i_flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
        tests_run++;
        if (instret_wb !== 64'd7) begin
            tests_failed++;
            $display("FAIL instret_count: got %0d, required 7", instret_wb);
        end
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        drive(1'b1, 32'h0, 5'd2, 1'b1, 2'b00, 4'b0000, 32'd0, 32'd0);
        tests_run++;
        if (instret_wb !== 64'd0) begin
            tests_failed++;
            $display("FAIL instret_wrap: got %h, required 0", instret_wb);
        end
    endtask
`endif

    initial begin
        i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        valid_mem = 1'b0; pc_mem = '0; rd_addr_mem = '0; rd_wren_mem = 1'b0;
        wb_sel_mem = '0; lsu_op_mem = '0; alu_data_mem = '0; ld_data = '0;
        #2;
        test_reset();
        test_loads();
        test_jal();
        test_x0_guard();
        test_stall_flush();
`ifdef STAGEWB_INSTRET_EN
        test_instret();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
